pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Central pipeline controller for the 5-stage RV32I core.
- Merges stall requests from the IF, ID and MEM stages into a per-stage stall vector that drives the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC.
- Sequences branch/jump redirects from EX, including redirects that arrive while an instruction fetch is still in flight. Such a redirect is held pending until the fetch completes, and the stale instruction is then flushed.
- Provides stall-cycle statistics and a stall watchdog.

Parameters:
- CNT_W, 16, width of the saturating stall-cycle counter.
- TIMEOUT, 1024, consecutive stalled cycles before the watchdog fires (≥2).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- stallreq_if  input  1  IF fetch not complete (instruction memory busy).
- stallreq_id  input  1  ID hazard (load-use).
- stallreq_mem  input  1  MEM data access not complete.
- branch_flag_i  input  1  EX resolves a taken branch/jump this cycle.
- branch_target_i  input  32  redirect target from EX.
- stall  output  6  stall vector: [0] PC, [1] IF, [2] ID, [3] EX, [4] MEM, [5] WB.
- flush  output  1  clear IF/ID and ID/EX to zero at the next edge.
- new_pc_valid  output  1  PC loads new_pc at the next edge.
- new_pc  output  32  redirect target.
- redirect_pending  output  1  state == PEND.
- stall_cycles  output  CNT_W  count of cycles with stall[0]=1; saturates at all-ones.
- stall_timeout  output  1  sticky watchdog flag.

Behaviour:
- **Reset.** While rst=1, all outputs are forced to 0 and new_pc is 0. On the reset edge: state←RUN, pend_pc←0, stall_cycles←0, run counter←0, stall_timeout←0. Reset in PEND discards the pending redirect.
- **Stall vector.** Combinational, fixed priority MEM > ID > IF:
  - stallreq_mem → 6'b011111
  - else stallreq_id → 6'b000111
  - else stallreq_if → 6'b000011
  - else 6'b000000
  - The stall vector is independent of state.
- **Branch acceptance.** A branch is accepted in a cycle where branch_flag_i=1 and stall[3]=0. With stall[3]=1, EX holds the branch and it is re-presented in a later cycle. No branch state is kept for a non-accepted branch.
- **State RUN:**
  - Accept with stallreq_if=0: flush=1, new_pc_valid=1, new_pc=branch_target_i, all in the same cycle (zero latency). State stays RUN.
  - Accept with stallreq_if=1: flush=1, new_pc_valid=0, pend_pc←branch_target_i, state→PEND.
- **State PEND:**
  - While stallreq_if=1: new_pc_valid=0 and flush=0.
  - First cycle with stallreq_if=0: new_pc_valid=1, new_pc=pend_pc, flush=1 (discards the stale fetched instruction), state→RUN.
  - A branch accepted in PEND overwrites pend_pc. If this happens in the exit cycle, new_pc=branch_target_i; the new target wins.
- **Counters:**
  - stall_cycles increments every cycle with stall[0]=1 and holds at 2^CNT_W−1.
  - The run counter increments while stall[0]=1 and clears to 0 on any cycle with stall[0]=0.
  - When the run counter reaches TIMEOUT−1 with stall[0] still 1, stall_timeout←1. It stays set until rst.
- **Output timing.** All outputs except stall_cycles, stall_timeout and redirect_pending are combinational from inputs and state. The three listed are registered.

Test Plan:
1. Reset with all requests asserted → stall=0, flush=0, new_pc_valid=0, stall_cycles=0. Release rst with stallreq_mem=1 → stall=6'b011111 in the same cycle.
2. Priority: stallreq_if=stallreq_id=1 → stall=6'b000111. Add stallreq_mem=1 → 6'b011111. Drop all three → 6'b000000.
3. Branch in RUN: branch_flag_i=1, target 0x0000_1000, no stalls → flush=1, new_pc_valid=1, new_pc=0x0000_1000 in the same cycle; state remains RUN.
4. Branch during fetch stall: stallreq_if=1, branch target 0x0000_2040 → flush=1, new_pc_valid=0, redirect_pending=1 next cycle. Hold stallreq_if for 3 cycles, then drop → exactly one cycle with new_pc_valid=1, new_pc=0x0000_2040, flush=1; redirect_pending returns to 0.
5. Branch under MEM stall: stallreq_mem=1, branch_flag_i=1 for 4 cycles, then stallreq_mem=0 → no flush or new_pc_valid while stalled; single redirect in the release cycle.
6. Counters with TIMEOUT=8, CNT_W=4:
   - stallreq_id held 7 cycles → stall_timeout=0.
   - Gap of 1 cycle, then held 8 cycles → stall_timeout=1 and remains 1 after the stall drops.
   - After 20 total stalled cycles, stall_cycles=15 (saturated).

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// Pipeline control bundle between the RV32I stage logic and the central
// pipeline controller. The pipeline side (master) raises stall requests and
// redirects; the controller (slave) returns the stall vector, flush and
// PC redirect along with stall statistics.
interface pipe_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             stallreq_if;
    logic             stallreq_id;
    logic             stallreq_mem;
    logic             branch_flag_i;
    logic [31:0]      branch_target_i;
    logic [5:0]       stall;
    logic             flush;
    logic             new_pc_valid;
    logic [31:0]      new_pc;
    logic             redirect_pending;
    logic [CNT_W-1:0] stall_cycles;
    logic             stall_timeout;

    modport master (
        output stallreq_if,
        output stallreq_id,
        output stallreq_mem,
        output branch_flag_i,
        output branch_target_i,
        input  stall,
        input  flush,
        input  new_pc_valid,
        input  new_pc,
        input  redirect_pending,
        input  stall_cycles,
        input  stall_timeout
    );

    modport slave (
        input  stallreq_if,
        input  stallreq_id,
        input  stallreq_mem,
        input  branch_flag_i,
        input  branch_target_i,
        output stall,
        output flush,
        output new_pc_valid,
        output new_pc,
        output redirect_pending,
        output stall_cycles,
        output stall_timeout
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Central pipeline controller for the 5-stage RV32I core: merges stage stall
// requests into a per-stage stall vector, sequences EX redirects (deferring
// them while an instruction fetch is still outstanding), and keeps stall
// statistics plus a sticky stall watchdog.
//
//   state | meaning
//   ------+----------------------------------------------------------------
//   RUN   | normal flow; an accepted redirect is issued in the same cycle
//   PEND  | redirect captured during a fetch stall; issued when fetch ends
module pipe_ctrl #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic         clk,
    input  logic         rst,
    pipe_ctrl_if.slave   bus
);

    localparam int RUN_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(TIMEOUT - 1);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_PEND = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      pend_pc_q, pend_pc_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
    logic             stall_timeout_q, stall_timeout_d;

    logic [5:0]       stall_vec;
    logic             accept;
    logic             flush;
    logic             new_pc_valid;
    logic [31:0]      new_pc;

    // Fixed-priority stall merge (MEM > ID > IF), held at zero during reset.
    always_comb begin
        stall_vec = 6'b000000;
        if (!rst) begin
            if (bus.stallreq_mem) begin
                stall_vec = 6'b011111;
            end else if (bus.stallreq_id) begin
                stall_vec = 6'b000111;
            end else if (bus.stallreq_if) begin
                stall_vec = 6'b000011;
            end
        end
    end

    // A branch held in a stalled EX stage is re-presented later, so only an
    // un-stalled EX counts as an accepted redirect.
    always_comb begin
        accept = !rst && bus.branch_flag_i && !stall_vec[3];
    end

    // Redirect sequencing: next state, pending target and redirect outputs.
    always_comb begin
        state_d      = state_q;
        pend_pc_d    = pend_pc_q;
        flush        = 1'b0;
        new_pc_valid = 1'b0;
        new_pc       = 32'h0000_0000;
        if (rst) begin
            state_d   = ST_RUN;
            pend_pc_d = 32'h0000_0000;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (accept) begin
                        flush = 1'b1;
                        if (!bus.stallreq_if) begin
                            new_pc_valid = 1'b1;
                            new_pc       = bus.branch_target_i;
                        end else begin
                            // Fetch still in flight: the PC cannot take the
                            // target yet, so park it until the fetch returns.
                            pend_pc_d = bus.branch_target_i;
                            state_d   = ST_PEND;
                        end
                    end
                end
                ST_PEND: begin
                    if (accept) begin
                        pend_pc_d = bus.branch_target_i;
                    end
                    if (!bus.stallreq_if) begin
                        // Fetch completed: drop the stale instruction and
                        // steer the PC; a redirect arriving now is younger.
                        flush        = 1'b1;
                        new_pc_valid = 1'b1;
                        new_pc       = accept ? bus.branch_target_i : pend_pc_q;
                        state_d      = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    // Saturating stall-cycle count, consecutive-stall run length, watchdog.
    always_comb begin
        stall_cycles_d  = stall_cycles_q;
        run_cnt_d       = run_cnt_q;
        stall_timeout_d = stall_timeout_q;
        if (stall_vec[0]) begin
            if (stall_cycles_q != {CNT_W{1'b1}}) begin
                stall_cycles_d = stall_cycles_q + CNT_W'(1);
            end
            if (run_cnt_q != RUN_LAST) begin
                run_cnt_d = run_cnt_q + RUN_W'(1);
            end
            if (run_cnt_q == RUN_LAST) begin
                stall_timeout_d = 1'b1;
            end
        end else begin
            run_cnt_d = '0;
        end
    end

    // State and statistics registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_RUN;
            pend_pc_q       <= 32'h0000_0000;
            stall_cycles_q  <= '0;
            run_cnt_q       <= '0;
            stall_timeout_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            pend_pc_q       <= pend_pc_d;
            stall_cycles_q  <= stall_cycles_d;
            run_cnt_q       <= run_cnt_d;
            stall_timeout_q <= stall_timeout_d;
        end
    end

    assign bus.stall            = stall_vec;
    assign bus.flush            = flush;
    assign bus.new_pc_valid     = new_pc_valid;
    assign bus.new_pc           = new_pc;
    assign bus.redirect_pending = (state_q == ST_PEND);
    assign bus.stall_cycles     = stall_cycles_q;
    assign bus.stall_timeout    = stall_timeout_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with a small counter and short watchdog.
module tb_pipe_ctrl;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    pipe_ctrl_if #(.CNT_W(4)) bus ();

    pipe_ctrl #(
        .CNT_W   (4),
        .TIMEOUT (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;

        // 1: reset with every request asserted
        rst                 = 1'b1;
        bus.stallreq_if     = 1'b1;
        bus.stallreq_id     = 1'b1;
        bus.stallreq_mem    = 1'b1;
        bus.branch_flag_i   = 1'b1;
        bus.branch_target_i = 32'hABCD_0000;
        settle();
        chk("rst_stall", 32'(bus.stall), 32'h00);
        chk("rst_flush", 32'(bus.flush), 32'h0);
        chk("rst_npv", 32'(bus.new_pc_valid), 32'h0);
        chk("rst_new_pc", bus.new_pc, 32'h0);
        tick();
        chk("rst_cycles", 32'(bus.stall_cycles), 32'h0);
        chk("rst_timeout", 32'(bus.stall_timeout), 32'h0);
        chk("rst_pending", 32'(bus.redirect_pending), 32'h0);
        rst                 = 1'b0;
        bus.stallreq_if     = 1'b0;
        bus.stallreq_id     = 1'b0;
        bus.branch_flag_i   = 1'b0;
        settle();
        chk("rel_mem_stall", 32'(bus.stall), 32'h1F);
        tick();
        chk("cycles_after_1", 32'(bus.stall_cycles), 32'd1);

        // 2: priority
        bus.stallreq_mem = 1'b0;
        bus.stallreq_if  = 1'b1;
        bus.stallreq_id  = 1'b1;
        settle();
        chk("prio_id_over_if", 32'(bus.stall), 32'h07);
        bus.stallreq_mem = 1'b1;
        settle();
        chk("prio_mem_top", 32'(bus.stall), 32'h1F);
        bus.stallreq_mem = 1'b0;
        bus.stallreq_id  = 1'b0;
        settle();
        chk("prio_if_only", 32'(bus.stall), 32'h03);
        bus.stallreq_if  = 1'b0;
        settle();
        chk("prio_none", 32'(bus.stall), 32'h00);
        tick();
        chk("cycles_hold_1", 32'(bus.stall_cycles), 32'd1);

        // 3: zero-latency branch in RUN
        bus.branch_flag_i   = 1'b1;
        bus.branch_target_i = 32'h0000_1000;
        settle();
        chk("run_br_flush", 32'(bus.flush), 32'h1);
        chk("run_br_npv", 32'(bus.new_pc_valid), 32'h1);
        chk("run_br_pc", bus.new_pc, 32'h0000_1000);
        tick();
        bus.branch_flag_i = 1'b0;
        settle();
        chk("run_br_pending", 32'(bus.redirect_pending), 32'h0);
        chk("run_br_flush_end", 32'(bus.flush), 32'h0);
        chk("run_br_npv_end", 32'(bus.new_pc_valid), 32'h0);

        // 4: branch while fetch is stalled
        bus.stallreq_if     = 1'b1;
        bus.branch_flag_i   = 1'b1;
        bus.branch_target_i = 32'h0000_2040;
        settle();
        chk("pend_acc_flush", 32'(bus.flush), 32'h1);
        chk("pend_acc_npv", 32'(bus.new_pc_valid), 32'h0);
        tick();
        bus.branch_flag_i   = 1'b0;
        bus.branch_target_i = 32'hDEAD_0000;
        settle();
        chk("pend_state", 32'(bus.redirect_pending), 32'h1);
        chk("pend_hold_flush", 32'(bus.flush), 32'h0);
        chk("pend_hold_npv", 32'(bus.new_pc_valid), 32'h0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("pend_hold_npv_loop", 32'(bus.new_pc_valid), 32'h0);
            chk("pend_hold_flush_loop", 32'(bus.flush), 32'h0);
        end
        tick();
        bus.stallreq_if = 1'b0;
        settle();
        chk("pend_exit_npv", 32'(bus.new_pc_valid), 32'h1);
        chk("pend_exit_pc", bus.new_pc, 32'h0000_2040);
        chk("pend_exit_flush", 32'(bus.flush), 32'h1);
        tick();
        chk("pend_after_npv", 32'(bus.new_pc_valid), 32'h0);
        chk("pend_after_flush", 32'(bus.flush), 32'h0);
        chk("pend_after_state", 32'(bus.redirect_pending), 32'h0);
        chk("cycles_after_pend", 32'(bus.stall_cycles), 32'd5);

        // 5: branch held in EX under MEM stall
        bus.stallreq_mem    = 1'b1;
        bus.branch_flag_i   = 1'b1;
        bus.branch_target_i = 32'h0000_3000;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("mem_hold_flush", 32'(bus.flush), 32'h0);
            chk("mem_hold_npv", 32'(bus.new_pc_valid), 32'h0);
            tick();
        end
        chk("mem_hold_pending", 32'(bus.redirect_pending), 32'h0);
        bus.stallreq_mem = 1'b0;
        settle();
        chk("mem_rel_npv", 32'(bus.new_pc_valid), 32'h1);
        chk("mem_rel_flush", 32'(bus.flush), 32'h1);
        chk("mem_rel_pc", bus.new_pc, 32'h0000_3000);
        tick();
        bus.branch_flag_i = 1'b0;
        settle();
        chk("mem_rel_done", 32'(bus.new_pc_valid), 32'h0);
        chk("cycles_after_mem", 32'(bus.stall_cycles), 32'd9);

        // PEND exit with a younger redirect arriving in the same cycle
        bus.stallreq_if     = 1'b1;
        bus.branch_flag_i   = 1'b1;
        bus.branch_target_i = 32'h0000_4000;
        tick();
        bus.stallreq_if     = 1'b0;
        bus.branch_target_i = 32'h0000_5000;
        settle();
        chk("pend_new_wins_pc", bus.new_pc, 32'h0000_5000);
        chk("pend_new_wins_npv", 32'(bus.new_pc_valid), 32'h1);
        tick();
        bus.branch_flag_i = 1'b0;
        settle();
        chk("pend_new_wins_state", 32'(bus.redirect_pending), 32'h0);
        chk("pend_new_wins_npv_end", 32'(bus.new_pc_valid), 32'h0);

        // 6: counters and watchdog from a clean reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("cnt_rst_cycles", 32'(bus.stall_cycles), 32'd0);
        bus.stallreq_id = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        chk("wd_7_timeout", 32'(bus.stall_timeout), 32'h0);
        chk("cnt_7", 32'(bus.stall_cycles), 32'd7);
        bus.stallreq_id = 1'b0;
        tick();
        chk("wd_gap_timeout", 32'(bus.stall_timeout), 32'h0);
        bus.stallreq_id = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        chk("wd_7b_timeout", 32'(bus.stall_timeout), 32'h0);
        tick();
        chk("wd_8_timeout", 32'(bus.stall_timeout), 32'h1);
        chk("cnt_15", 32'(bus.stall_cycles), 32'd15);
        bus.stallreq_id = 1'b0;
        tick();
        chk("wd_sticky", 32'(bus.stall_timeout), 32'h1);
        bus.stallreq_id = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("cnt_saturated", 32'(bus.stall_cycles), 32'd15);
        bus.stallreq_id = 1'b0;
        rst = 1'b1;
        tick();
        chk("wd_rst_clear", 32'(bus.stall_timeout), 32'h0);
        chk("cnt_rst_clear", 32'(bus.stall_cycles), 32'd0);
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
